// File: rtl/usb_pkg.sv
// Shared types and constants for the USB receive datapath.
package usb_pkg;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_ERR  = 2'd2
  } usb_rx_state_t;

  localparam int USB_STUFF_LEN = 6;

endpackage

// File: rtl/usb_bit_unstuffer.sv
// Tracks consecutive 1s on the received bit stream and classifies each strobe
// as a data bit, a dropped stuffed bit, or a stuffing violation.
module usb_bit_unstuffer #(
  parameter int STUFF_LEN = 6
) (
  input  logic clk,
  input  logic nRST,
  input  logic strobe_i,
  input  logic serial_i,
  input  logic clear_i,
  output logic bit_valid_o,
  output logic bit_val_o,
  output logic stuff_err_o
);

  localparam int            OW    = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] LIMIT = OW'(STUFF_LEN);

  logic [OW-1:0] ones_q, ones_d;
  logic          at_limit;

  assign at_limit    = (ones_q == LIMIT);
  assign bit_valid_o = strobe_i && !at_limit;
  assign bit_val_o   = serial_i;
  assign stuff_err_o = strobe_i && at_limit && serial_i;

  // The run length carries across byte boundaries; only packet end or a
  // stuffed-bit slot (legal or not) restarts it.
  always_comb begin
    ones_d = ones_q;
    if (clear_i) begin
      ones_d = '0;
    end else if (strobe_i) begin
      if (at_limit || !serial_i) ones_d = '0;
      else if (ones_q != '1)     ones_d = ones_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) ones_q <= '0;
    else       ones_q <= ones_d;
  end

endmodule

// File: rtl/usb_rx_sipo.sv
// Receive deserializer: unstuffs NRZI-decoded bits, assembles bytes and hands
// them to the packet decoder through a one-entry valid/ready holding register.
module usb_rx_sipo
  import usb_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int STUFF_LEN = USB_STUFF_LEN
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       sample_en,
  input  logic       serial_in,
  input  logic       rx_active,
  input  logic       byte_ready,
  output logic [7:0] data_out,
  output logic       byte_valid,
  output logic       busy,
  output logic       stuff_err,
  output logic       overflow,
  output logic       partial_err
);

  usb_rx_state_t state_q;
  logic [6:0]    shifter_q, shifter_d;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    data_q, byte_d;
  logic          valid_q, stuff_err_q, overflow_q, partial_err_q;
  logic          strobe, pkt_end, bit_valid, bit_val, stuff_hit, byte_done;

  // A strobe in the IDLE cycle that sees rx_active rise is already a data bit.
  assign strobe    = (state_q != RX_ERR) && rx_active && sample_en;
  assign pkt_end   = (state_q == RX_RECV) && !rx_active;
  assign byte_done = bit_valid && (bit_cnt_q == 3'd7);

  usb_bit_unstuffer #(.STUFF_LEN(STUFF_LEN)) u_unstuffer (
    .clk         (clk),
    .nRST        (nRST),
    .strobe_i    (strobe),
    .serial_i    (serial_in),
    .clear_i     (pkt_end),
    .bit_valid_o (bit_valid),
    .bit_val_o   (bit_val),
    .stuff_err_o (stuff_hit)
  );

  always_comb begin
    if (MSB_FIRST) begin
      shifter_d = {shifter_q[5:0], bit_val};
      byte_d    = {shifter_q, bit_val};
    end else begin
      shifter_d = {bit_val, shifter_q[6:1]};
      byte_d    = {bit_val, shifter_q};
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q       <= RX_IDLE;
      shifter_q     <= '0;
      bit_cnt_q     <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      stuff_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
      partial_err_q <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle; a later assignment in this
      // block overrides the default for the one cycle the event occurs.
      stuff_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
      partial_err_q <= 1'b0;

      if (valid_q && byte_ready) valid_q <= 1'b0;
      if (byte_done) begin
        if (!valid_q || byte_ready) begin
          data_q  <= byte_d;
          valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end

      case (state_q)
        RX_IDLE: if (rx_active) state_q <= RX_RECV;
        RX_RECV: begin
          if (!rx_active) begin
            state_q       <= RX_IDLE;
            partial_err_q <= (bit_cnt_q != 3'd0);
            bit_cnt_q     <= '0;
            shifter_q     <= '0;
          end
        end
        RX_ERR:  if (!rx_active) state_q <= RX_IDLE;
        default: state_q <= RX_IDLE;
      endcase

      if (stuff_hit) begin
        stuff_err_q <= 1'b1;
        state_q     <= RX_ERR;
        bit_cnt_q   <= '0;
        shifter_q   <= '0;
      end else if (bit_valid) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        shifter_q <= shifter_d;
      end
    end
  end

  assign data_out    = data_q;
  assign byte_valid  = valid_q;
  assign busy        = (bit_cnt_q != 3'd0);
  assign stuff_err   = stuff_err_q;
  assign overflow    = overflow_q;
  assign partial_err = partial_err_q;

endmodule

// File: tb/tb_usb_rx_sipo.sv
// Self-checking bench for usb_rx_sipo: directed scenarios plus randomized
// packets compared against a byte-level sender/receiver model.
module tb_usb_rx_sipo;

  logic       clk = 1'b0;
  logic       nRST, sample_en, serial_in, rx_active, byte_ready;
  logic [7:0] data_out;
  logic       byte_valid, busy, stuff_err, overflow, partial_err;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor record: delivered bytes and pulse counts, written only by the monitor.
  logic [7:0] rx_log [0:511];
  int rx_n = 0, n_stuff = 0, n_ovf = 0, n_part = 0;
  int b_log, b_st, b_ov, b_pa;

  int tx_ones = 0;
  int gap_max = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  usb_rx_sipo dut (
    .clk         (clk),
    .nRST        (nRST),
    .sample_en   (sample_en),
    .serial_in   (serial_in),
    .rx_active   (rx_active),
    .byte_ready  (byte_ready),
    .data_out    (data_out),
    .byte_valid  (byte_valid),
    .busy        (busy),
    .stuff_err   (stuff_err),
    .overflow    (overflow),
    .partial_err (partial_err)
  );

  // Inputs only change at posedge+2, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (nRST === 1'b1) begin
      if (byte_valid && byte_ready && rx_n < 512) begin
        rx_log[rx_n] <= data_out;
        rx_n         <= rx_n + 1;
      end
      if (stuff_err)   n_stuff <= n_stuff + 1;
      if (overflow)    n_ovf   <= n_ovf + 1;
      if (partial_err) n_part  <= n_part + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic snap();
    b_log = rx_n; b_st = n_stuff; b_ov = n_ovf; b_pa = n_part;
  endtask

  task automatic send_bit(input logic b);
    sample_en = 1'b1;
    serial_in = b;
    step();
    sample_en = 1'b0;
    repeat ($urandom_range(0, gap_max)) begin
      serial_in = 1'($urandom);
      step();
    end
  endtask

  // Transmitter-side stuffing: a 0 goes on the wire after every sixth consecutive 1.
  task automatic send_data_bit(input logic b);
    send_bit(b);
    tx_ones = b ? tx_ones + 1 : 0;
    if (tx_ones == 6) begin
      send_bit(1'b0);
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_data_bit(d[i]);
  endtask

  task automatic pkt_start();
    rx_active = 1'b1;
    tx_ones   = 0;
  endtask

  task automatic pkt_stop();
    rx_active = 1'b0;
    sample_en = 1'b0;
    repeat (3) step();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"}, data_out, 0);
    check({tag, "_flags"}, {byte_valid, busy, stuff_err, overflow, partial_err}, 0);
  endtask

  initial begin
    logic [7:0] d;
    nRST = 1'b0; sample_en = 1'b0; serial_in = 1'b0; rx_active = 1'b0; byte_ready = 1'b1;
    repeat (2) step();
    check_outputs_zero("reset");
    nRST = 1'b1;
    step();

    // Reset in the middle of a byte discards the partial byte.
    d = 8'hA5;
    pkt_start();
    for (int i = 7; i >= 3; i--) send_data_bit(d[i]);
    check("mid_busy", busy, 1);
    #1 nRST = 1'b0;
    #1 check_outputs_zero("async_reset");
    step();
    rx_active = 1'b0;
    nRST = 1'b1;
    repeat (2) step();

    snap();
    pkt_start();
    send_byte(8'hA5);
    check("lat_valid", byte_valid, 1);
    check("lat_data", data_out, 8'hA5);
    pkt_stop();
    check("a5_count", rx_n - b_log, 1);
    check("a5_byte", rx_log[b_log], 8'hA5);

    // Two-byte stream, consumer always ready.
    snap();
    pkt_start();
    send_byte(8'hA5);
    send_byte(8'h3C);
    pkt_stop();
    check("stream_count", rx_n - b_log, 2);
    check("stream_b0", rx_log[b_log], 8'hA5);
    check("stream_b1", rx_log[b_log + 1], 8'h3C);
    check("stream_pulses", (n_stuff - b_st) + (n_ovf - b_ov) + (n_part - b_pa), 0);

    // Legal stuffed bit inside 0xFF, then 0x00.
    snap();
    pkt_start();
    send_byte(8'hFF);
    check("ff_data", data_out, 8'hFF);
    send_byte(8'h00);
    pkt_stop();
    check("stuff_count", rx_n - b_log, 2);
    check("stuff_b0", rx_log[b_log], 8'hFF);
    check("stuff_b1", rx_log[b_log + 1], 8'h00);
    check("stuff_no_err", n_stuff - b_st, 0);

    // Stuffing violation: seven 1s on the wire.
    snap();
    pkt_start();
    repeat (7) send_bit(1'b1);
    check("serr_pulse", stuff_err, 1);
    step();
    check("serr_width", stuff_err, 0);
    d = 8'h55;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    step();
    check("serr_ignored_busy", busy, 0);
    check("serr_ignored_log", rx_n - b_log, 0);
    pkt_stop();
    check("serr_count", n_stuff - b_st, 1);
    check("serr_no_partial", n_part - b_pa, 0);
    snap();
    pkt_start();
    send_byte(8'h12);
    pkt_stop();
    check("serr_recover_count", rx_n - b_log, 1);
    check("serr_recover_byte", rx_log[b_log], 8'h12);

    // Backpressure: second byte overflows, then ready coincides with completion.
    snap();
    byte_ready = 1'b0;
    pkt_start();
    send_byte(8'h11);
    send_byte(8'h22);
    check("ovf_pulse", overflow, 1);
    check("ovf_keep", data_out, 8'h11);
    check("ovf_valid", byte_valid, 1);
    d = 8'h22;
    for (int i = 7; i >= 1; i--) send_data_bit(d[i]);
    byte_ready = 1'b1;
    send_data_bit(d[0]);
    check("simul_data", data_out, 8'h22);
    check("simul_valid", byte_valid, 1);
    check("simul_no_ovf", overflow, 0);
    pkt_stop();
    check("bp_count", rx_n - b_log, 2);
    check("bp_b0", rx_log[b_log], 8'h11);
    check("bp_b1", rx_log[b_log + 1], 8'h22);
    check("bp_ovf_count", n_ovf - b_ov, 1);

    // Short packet with a byte still held.
    snap();
    byte_ready = 1'b0;
    pkt_start();
    send_byte(8'h5A);
    send_data_bit(1'b1); send_data_bit(1'b0); send_data_bit(1'b1);
    check("short_busy", busy, 1);
    rx_active = 1'b0;
    step();
    check("short_perr", partial_err, 1);
    check("short_busy_clr", busy, 0);
    check("short_hold", {byte_valid, data_out}, {1'b1, 8'h5A});
    step();
    check("short_perr_width", partial_err, 0);
    byte_ready = 1'b1;
    repeat (2) step();
    check("short_deliver", rx_n - b_log, 1);
    check("short_byte", rx_log[b_log], 8'h5A);
    check("short_drained", byte_valid, 0);

    // Strobes with rx_active low are ignored.
    snap();
    repeat (9) send_bit(1'b1);
    check("inactive_busy", busy, 0);
    check("inactive_pulses", {stuff_err, byte_valid}, 0);
    check("inactive_log", rx_n - b_log, 0);

    // Randomized packets with strobe gaps, stuffing-heavy byte mix.
    snap();
    gap_max = 2;
    for (int p = 0; p < 8; p++) begin
      pkt_start();
      for (int b = 0; b < int'($urandom_range(1, 5)); b++) begin
        d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        exp_q.push_back(d);
        send_byte(d);
      end
      pkt_stop();
    end
    gap_max = 0;
    check("rand_count", rx_n - b_log, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) check("rand_byte", rx_log[b_log + k], exp_q[k]);
    check("rand_pulses", (n_stuff - b_st) + (n_ovf - b_ov) + (n_part - b_pa), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
